// File: rtl/vga_timing_if.sv
// Video timing bundle: pixel strobe in, sync/blank/coordinate/pulse outputs.
interface vga_timing_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic          i_pix_stb;
    logic          o_hs;
    logic          o_vs;
    logic          o_de;
    logic          o_hblank;
    logic          o_vblank;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic          o_frame_start;
    logic          o_line_start;
    logic          o_animate;

    // Timing generator side.
    modport master (
        input  i_pix_stb,
        output o_hs, o_vs, o_de, o_hblank, o_vblank,
        output o_x, o_y, o_frame_start, o_line_start, o_animate
    );

    // Pixel generator / consumer side.
    modport slave (
        output i_pix_stb,
        input  o_hs, o_vs, o_de, o_hblank, o_vblank,
        input  o_x, o_y, o_frame_start, o_line_start, o_animate
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. Outputs are registered from the
// next-state counter values, so they line up with the counters on every edge.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    vga_timing_if.master bus
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [XW-1:0] h_cnt_q, h_cnt_d;
    logic [YW-1:0] v_cnt_q, v_cnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          frame_start_q, frame_start_d;
    logic          line_start_q, line_start_d;
    logic          animate_q, animate_d;

    // Counter advance on pixel strobe; vertical steps on horizontal wrap.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (bus.i_pix_stb) begin
            if (32'(h_cnt_q) == H_TOTAL - 1) begin
                h_cnt_d = '0;
                if (32'(v_cnt_q) == V_TOTAL - 1) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + YW'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + XW'(1);
            end
        end
    end

    // Output decode from next counter values; pulses only on a strobe edge.
    always_comb begin
        hblank_d      = 32'(h_cnt_d) >= H_ACTIVE;
        vblank_d      = 32'(v_cnt_d) >= V_ACTIVE;
        de_d          = !hblank_d && !vblank_d;
        hs_d          = ((32'(h_cnt_d) >= HS_START) && (32'(h_cnt_d) < HS_END)) ? HS_POL : !HS_POL;
        vs_d          = ((32'(v_cnt_d) >= VS_START) && (32'(v_cnt_d) < VS_END)) ? VS_POL : !VS_POL;
        x_d           = hblank_d ? XW'(H_ACTIVE - 1) : h_cnt_d;
        y_d           = vblank_d ? YW'(V_ACTIVE - 1) : v_cnt_d;
        line_start_d  = bus.i_pix_stb && (h_cnt_d == '0);
        frame_start_d = line_start_d && (v_cnt_d == '0);
        animate_d     = line_start_d && (32'(v_cnt_d) == V_ACTIVE);
    end

    // State and output registers; reset parks on the last back-porch pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt_q       <= XW'(H_TOTAL - 1);
            v_cnt_q       <= YW'(V_TOTAL - 1);
            hs_q          <= !HS_POL;
            vs_q          <= !VS_POL;
            de_q          <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            x_q           <= XW'(H_ACTIVE - 1);
            y_q           <= YW'(V_ACTIVE - 1);
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            animate_q     <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            animate_q     <= animate_d;
        end
    end

    assign bus.o_hs          = hs_q;
    assign bus.o_vs          = vs_q;
    assign bus.o_de          = de_q;
    assign bus.o_hblank      = hblank_q;
    assign bus.o_vblank      = vblank_q;
    assign bus.o_x           = x_q;
    assign bus.o_y           = y_q;
    assign bus.o_frame_start = frame_start_q;
    assign bus.o_line_start  = line_start_q;
    assign bus.o_animate     = animate_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing (line level), a tiny config
// (table-driven, strobe tied high) and a small config for frame-level behaviour.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic stb_a, stb_c;

    vga_timing_if #(.XW(10), .YW(10)) bus_a ();
    vga_timing_if #(.XW(3),  .YW(3))  bus_b ();
    vga_timing_if #(.XW(5),  .YW(5))  bus_c ();

    assign bus_a.i_pix_stb = stb_a;
    assign bus_b.i_pix_stb = 1'b1;
    assign bus_c.i_pix_stb = stb_c;

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
        .HS_POL(1'b0), .VS_POL(1'b0), .XW(10), .YW(10)
    ) dut_a (.i_clk(clk), .i_rst(rst_a), .bus(bus_a.master));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .XW(3), .YW(3)
    ) dut_b (.i_clk(clk), .i_rst(rst_b), .bus(bus_b.master));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0), .XW(5), .YW(5)
    ) dut_c (.i_clk(clk), .i_rst(rst_c), .bus(bus_c.master));

    // Flag vectors ordered {hs, vs, de, hblank, vblank, frame_start, line_start, animate}.
    logic [7:0] fa, fb, fc;
    assign fa = {bus_a.o_hs, bus_a.o_vs, bus_a.o_de, bus_a.o_hblank, bus_a.o_vblank,
                 bus_a.o_frame_start, bus_a.o_line_start, bus_a.o_animate};
    assign fb = {bus_b.o_hs, bus_b.o_vs, bus_b.o_de, bus_b.o_hblank, bus_b.o_vblank,
                 bus_b.o_frame_start, bus_b.o_line_start, bus_b.o_animate};
    assign fc = {bus_c.o_hs, bus_c.o_vs, bus_c.o_de, bus_c.o_hblank, bus_c.o_vblank,
                 bus_c.o_frame_start, bus_c.o_line_start, bus_c.o_animate};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         n;
        logic [7:0] flags;
        int         x;
        int         y;
    } vec_t;

    vec_t tv[$];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, h, v, n;
        int de_n, hs_n, xs_n, ls_n, fs_n;
        logic [7:0] ef;
        int ex, ey;
        int s, p, last_fs, fsc, vs_n, vb_n, hs_c, an_n, ymax;
        logic vs_prev;

        // Tiny config: edge number after reset release -> expected outputs.
        tv.push_back('{1,  8'b00100110, 0, 0});
        tv.push_back('{2,  8'b00100000, 1, 0});
        tv.push_back('{4,  8'b00100000, 3, 0});
        tv.push_back('{5,  8'b00010000, 3, 0});
        tv.push_back('{6,  8'b10010000, 3, 0});
        tv.push_back('{7,  8'b10010000, 3, 0});
        tv.push_back('{8,  8'b00010000, 3, 0});
        tv.push_back('{9,  8'b00100010, 0, 1});
        tv.push_back('{20, 8'b00100000, 3, 2});
        tv.push_back('{25, 8'b00001011, 0, 2});
        tv.push_back('{26, 8'b00001000, 1, 2});
        tv.push_back('{33, 8'b01001010, 0, 2});
        tv.push_back('{38, 8'b11011000, 3, 2});
        tv.push_back('{40, 8'b01011000, 3, 2});
        tv.push_back('{41, 8'b00001010, 0, 2});
        tv.push_back('{48, 8'b00011000, 3, 2});
        tv.push_back('{49, 8'b00100110, 0, 0});
        tv.push_back('{97, 8'b00100110, 0, 0});

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        stb_a = 1'b0; stb_c = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- default config ----------------
        check("a_rst_flags", 32'(fa), 32'(8'b11011000));
        check("a_rst_x", 32'(bus_a.o_x), 639);
        check("a_rst_y", 32'(bus_a.o_y), 479);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        check("a_idle_flags", 32'(fa), 32'(8'b11011000));
        check("a_idle_x", 32'(bus_a.o_x), 639);

        // Two lines, strobe every 2nd cycle.
        k = 0; de_n = 0; hs_n = 0; xs_n = 0; ls_n = 0; fs_n = 0;
        ef = 8'b11011000; ex = 639; ey = 479;
        for (int c = 0; c < 3200; c++) begin
            stb_a = (c % 2 == 0);
            @(negedge clk);
            if (stb_a) begin
                h = k % 800; v = k / 800; k++;
                ex = (h < 640) ? h : 639;
                ey = (v < 480) ? v : 479;
                ef = {!(h >= 656 && h < 752), !(v >= 490 && v < 492),
                      (h < 640 && v < 480), (h >= 640), (v >= 480),
                      (h == 0 && v == 0), (h == 0), (h == 0 && v == 480)};
                if (bus_a.o_de) de_n++;
                if (!bus_a.o_hs) hs_n++;
                if (bus_a.o_hblank && bus_a.o_x == 10'd639) xs_n++;
            end else begin
                ef[2:0] = 3'b000;
            end
            if (bus_a.o_line_start) ls_n++;
            if (bus_a.o_frame_start) fs_n++;
            check("a_line_flags", 32'(fa), 32'(ef));
            check("a_line_x", 32'(bus_a.o_x), 32'(ex));
            check("a_line_y", 32'(bus_a.o_y), 32'(ey));
        end
        check("a_de_count", 32'(de_n), 1280);
        check("a_hs_count", 32'(hs_n), 192);
        check("a_xsat_count", 32'(xs_n), 320);
        check("a_ls_count", 32'(ls_n), 2);
        check("a_fs_count", 32'(fs_n), 1);

        // Continuous strobe to (100,2), then stall 100 cycles.
        stb_a = 1'b1;
        repeat (101) @(negedge clk);
        stb_a = 1'b0;
        check("a_pre_stall_x", 32'(bus_a.o_x), 100);
        check("a_pre_stall_y", 32'(bus_a.o_y), 2);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("a_stall_flags", 32'(fa), 32'(8'b11100000));
            check("a_stall_x", 32'(bus_a.o_x), 100);
        end
        stb_a = 1'b1;
        @(negedge clk);
        check("a_resume_x", 32'(bus_a.o_x), 101);
        check("a_resume_flags", 32'(fa), 32'(8'b11100000));

        // Reset mid-line at (300,2) with strobe active.
        repeat (199) @(negedge clk);
        check("a_midline_x", 32'(bus_a.o_x), 300);
        #2 rst_a = 1'b1;
        #1;
        check("a_async_rst_flags", 32'(fa), 32'(8'b11011000));
        check("a_async_rst_x", 32'(bus_a.o_x), 639);
        check("a_async_rst_y", 32'(bus_a.o_y), 479);
        repeat (3) @(negedge clk);
        check("a_rst_hold_flags", 32'(fa), 32'(8'b11011000));
        rst_a = 1'b0;
        @(negedge clk);
        check("a_first_flags", 32'(fa), 32'(8'b11100110));
        check("a_first_x", 32'(bus_a.o_x), 0);
        check("a_first_y", 32'(bus_a.o_y), 0);
        // Reset during the frame_start pulse.
        #2 rst_a = 1'b1;
        #1;
        check("a_pulse_rst_flags", 32'(fa), 32'(8'b11011000));
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("a_rerelease_flags", 32'(fa), 32'(8'b11100110));
        stb_a = 1'b0;
        @(negedge clk);
        check("a_pulse_drop_flags", 32'(fa), 32'(8'b11100000));
        check("a_pulse_drop_x", 32'(bus_a.o_x), 0);

        // ---------------- tiny config, strobe tied high ----------------
        check("b_rst_flags", 32'(fb), 32'(8'b00011000));
        check("b_rst_x", 32'(bus_b.o_x), 3);
        check("b_rst_y", 32'(bus_b.o_y), 2);
        rst_b = 1'b0;
        n = 0;
        foreach (tv[i]) begin
            repeat (tv[i].n - n) @(posedge clk);
            n = tv[i].n;
            @(negedge clk);
            check($sformatf("b_vec%0d_flags", tv[i].n), 32'(fb), 32'(tv[i].flags));
            check($sformatf("b_vec%0d_x", tv[i].n), 32'(bus_b.o_x), 32'(tv[i].x));
            check($sformatf("b_vec%0d_y", tv[i].n), 32'(bus_b.o_y), 32'(tv[i].y));
        end

        // ---------------- small config, frame level ----------------
        // H_TOTAL=24, V_TOTAL=19 -> 456 strobes per frame, 912 cycles at half rate.
        rst_c = 1'b0;
        @(negedge clk);
        s = 0; last_fs = -1; fsc = 0; vs_n = 0; vb_n = 0; hs_c = 0; an_n = 0; ymax = 0;
        vs_prev = bus_c.o_vs;
        for (int c = 0; c < 1840; c++) begin
            stb_c = (c % 2 == 0);
            @(negedge clk);
            if (stb_c) begin
                p = s; s++;
                if (p < 912) begin
                    if (!bus_c.o_vs) vs_n++;
                    if (bus_c.o_vblank) vb_n++;
                    if (!bus_c.o_hs) hs_c++;
                    if (bus_c.o_animate) an_n++;
                end
                if (32'(bus_c.o_y) > 32'(ymax)) ymax = 32'(bus_c.o_y);
            end else begin
                check("c_no_pulse", 32'(fc[2:0]), 0);
            end
            if (bus_c.o_frame_start) begin
                fsc++;
                check("c_fs_pos", {bus_c.o_x, bus_c.o_y}, 0);
                if (last_fs >= 0) check("c_frame_period", 32'(c - last_fs), 912);
                last_fs = c;
            end
            if (bus_c.o_animate) begin
                check("c_animate_flags", 32'(fc), 32'(8'b11001011));
                check("c_animate_y", 32'(bus_c.o_y), 11);
            end
            if (bus_c.o_vs != vs_prev) check("c_vs_edge_x", 32'(bus_c.o_x), 0);
            vs_prev = bus_c.o_vs;
        end
        check("c_fs_count", 32'(fsc), 3);
        check("c_vs_count", 32'(vs_n), 96);
        check("c_vblank_count", 32'(vb_n), 336);
        check("c_hs_count", 32'(hs_c), 114);
        check("c_animate_count", 32'(an_n), 2);
        check("c_ymax", 32'(ymax), 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/arcade raster timing generator. Next generation of the fixed 640x480 timing block.
- Porch, sync and active lengths, sync polarities and coordinate widths are all parameters.
- Adds data-enable, separate blanking flags, and frame-start, line-start and end-of-active-frame (animate) pulses.
- Sits between the board clock/strobe divider and the pixel generators of the test and JAMMA video paths.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
XW, 10, width of o_x and horizontal counter; must hold H_TOTAL-1
YW, 10, width of o_y and vertical counter; must hold V_TOTAL-1

Ports:
i_clk  in  1  system clock; only clock in the block
i_rst  in  1  asynchronous reset, active-high
i_pix_stb  in  1  pixel-rate enable, one i_clk cycle wide
o_hs  out  1  horizontal sync at HS_POL level when active
o_vs  out  1  vertical sync at VS_POL level when active
o_de  out  1  pixel is in the active area
o_hblank  out  1  horizontal counter is outside active pixels
o_vblank  out  1  vertical counter is outside active lines
o_x  out  XW  horizontal position, saturated to H_ACTIVE-1 in blanking
o_y  out  YW  vertical position, saturated to V_ACTIVE-1 in blanking
o_frame_start  out  1  one-cycle pulse: counters entered (0,0)
o_line_start  out  1  one-cycle pulse: horizontal counter entered 0
o_animate  out  1  one-cycle pulse: counters entered (0,V_ACTIVE)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise for the vertical parameters.
- Line order: active first, then front porch, sync, back porch. Active area is h_cnt < H_ACTIVE, v_cnt < V_ACTIVE.
- Counter advance: counters move only on an i_clk edge with i_pix_stb=1.
  - h_cnt increments, and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments, and wraps V_TOTAL-1 -> 0.
  - With i_pix_stb=0, counters and all level outputs hold.
- Output timing: every output is a register, updated on the same edge as the counters, from the new counter values. Latency from counter state to outputs is zero.
- Sync windows:
  - o_hs active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - o_vs active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - o_vs changes only together with an h_cnt wrap.
- Other level outputs: o_hblank = (h_cnt >= H_ACTIVE); o_vblank = (v_cnt >= V_ACTIVE); o_de = !o_hblank & !o_vblank.
- Coordinates: o_x = min(h_cnt, H_ACTIVE-1); o_y = min(v_cnt, V_ACTIVE-1).
- Pulses:
  - Each pulse is high for exactly one i_clk cycle: the cycle after the strobe edge that produced the qualifying counter values.
  - Pulses are low on every cycle without a preceding strobe. They never stretch when strobes are back-to-back.
  - o_frame_start and o_line_start are asserted together at (0,0).
- Reset (asynchronous, active-high): counters forced to (H_TOTAL-1, V_TOTAL-1), the last back-porch pixel. Output values during and after reset:
  - o_hs = !HS_POL, o_vs = !VS_POL.
  - o_de = 0, o_hblank = 1, o_vblank = 1.
  - o_x = H_ACTIVE-1, o_y = V_ACTIVE-1.
  - All pulses 0.
- After reset release, the first strobe gives (0,0): o_frame_start=1, o_line_start=1, o_de=1.
- Reset asserted mid-frame or mid-pulse overrides immediately; the same sequence follows release.
- i_pix_stb held high continuously is legal: one pixel per i_clk.

Test Plan:
- Defaults, reset then strobe every 2nd cycle for 2 frames -> o_frame_start every 840000 i_clk cycles. First pulse on the first strobe after release, together with o_line_start and o_de=1, x=0, y=0.
- Defaults, one line -> o_de high for 640 strobes. o_hs low exactly for h_cnt 656..751 (96 strobes). o_x reads 639 during h_cnt 640..799.
- Defaults, one frame -> o_vs low for v_cnt 490..491 (1600 strobes). o_animate single pulse at (0,480). o_vblank high for lines 480..524. o_y saturates at 479.
- Tiny config (H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1), i_pix_stb tied high -> H_TOTAL=8, V_TOTAL=6. Frame period 48 cycles. o_hs high for h_cnt 5,6; o_vs high for v_cnt 4.
- Reset asserted mid-line at (300,200) with strobe active -> outputs immediately take reset values. After release, the next strobe yields frame_start with x=0, y=0.
- i_pix_stb held low for 100 cycles mid-line -> all outputs frozen, no pulses. Resuming continues from the same h_cnt.
